// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the load/store unit
package lsu_pkg;

    localparam logic [1:0] LW = 2'b00;
    localparam logic [1:0] LB = 2'b01;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [1:0] SB = 2'b11;

    // The word address lives in a parallel array so ADDR_W stays a per-instance parameter.
    typedef struct packed {
        logic        valid;
        logic [3:0]  mask;
        logic [31:0] data;
    } sq_entry_t;

    function automatic logic [3:0] lane_mask(input logic is_byte, input logic [1:0] lane);
        lane_mask = is_byte ? (4'b0001 << lane) : 4'b1111;
    endfunction

endpackage

// File: rtl/sq_fwd_match.sv
// rtl/sq_fwd_match.sv - age-ordered search of the store queue for load forwarding
module sq_fwd_match
    import lsu_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  sq_entry_t         entries [DEPTH],
    input  logic [ADDR_W-3:0] waddr   [DEPTH],
    input  logic [IDX_W-1:0]  head,
    input  logic [IDX_W:0]    count,
    input  logic [ADDR_W-3:0] req_waddr,
    input  logic              req_byte,
    input  logic [1:0]        req_lane,
    output logic              hit,
    output logic              stall,
    output logic [31:0]       data
);

    logic [3:0]       req_mask;
    logic             found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] idx;
    logic             covers;
    logic [31:0]      shifted;

    assign req_mask = lane_mask(req_byte, req_lane);

    // Walk oldest to youngest; each later match overrides, so the youngest wins.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + IDX_W'(i);
            if (((IDX_W+1)'(i) < count) && entries[idx].valid &&
                (waddr[idx] == req_waddr) && |(entries[idx].mask & req_mask)) begin
                found   = 1'b1;
                sel_idx = idx;
            end
        end
    end

    always_comb begin
        covers  = ((entries[sel_idx].mask & req_mask) == req_mask);
        shifted = entries[sel_idx].data >> {req_lane, 3'b000};
        hit     = found && covers;
        stall   = found && !covers;
        data    = '0;
        if (hit) begin
            data = req_byte ? {24'b0, shifted[7:0]} : entries[sel_idx].data;
        end
    end

endmodule

// File: rtl/store_queue_fwd.sv
// rtl/store_queue_fwd.sv - in-order store queue with memory drain and load forwarding
module store_queue_fwd
    import lsu_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [ADDR_W-1:0] enq_addr,
    input  logic [DATA_W-1:0] enq_data,
    input  logic              enq_byte,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [3:0]        mem_mask,
    input  logic [ADDR_W-1:0] fwd_addr,
    input  logic              fwd_byte,
    output logic              fwd_hit,
    output logic              fwd_stall,
    output logic [DATA_W-1:0] fwd_data,
    output logic [IDX_W:0]    count,
    output logic              full,
    output logic              empty
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

    sq_entry_t         entries [DEPTH];
    logic [ADDR_W-3:0] waddr   [DEPTH];
    logic [IDX_W-1:0]  head;
    logic [IDX_W-1:0]  tail;
    logic [IDX_W:0]    count_q;
    logic              do_enq;
    logic              do_deq;

    assign full          = (count_q == FULL_CNT);
    assign empty         = (count_q == '0);
    assign count         = count_q;
    assign enq_ready     = !full;
    assign mem_req_valid = !empty;
    assign do_enq        = enq_valid && enq_ready;
    assign do_deq        = mem_req_valid && mem_req_ready;

    assign mem_addr = {waddr[head], 2'b00};
    assign mem_data = entries[head].data;
    assign mem_mask = entries[head].mask;

    // Head and tail only coincide when empty or full, so enqueue and drain never hit the same slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            if (do_enq) begin
                entries[tail].valid <= 1'b1;
                entries[tail].mask  <= lane_mask(enq_byte, enq_addr[1:0]);
                entries[tail].data  <= enq_byte ? {4{enq_data[7:0]}} : enq_data;
                waddr[tail]         <= enq_addr[ADDR_W-1:2];
                tail                <= tail + 1'b1;
            end
            if (do_deq) begin
                entries[head].valid <= 1'b0;
                head                <= head + 1'b1;
            end
            if (do_enq && !do_deq) begin
                count_q <= count_q + 1'b1;
            end else if (!do_enq && do_deq) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    sq_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_match (
        .entries   (entries),
        .waddr     (waddr),
        .head      (head),
        .count     (count_q),
        .req_waddr (fwd_addr[ADDR_W-1:2]),
        .req_byte  (fwd_byte),
        .req_lane  (fwd_addr[1:0]),
        .hit       (fwd_hit),
        .stall     (fwd_stall),
        .data      (fwd_data)
    );

endmodule

// File: doc/store_queue_fwd.md
Name: store_queue_fwd

Overview:
Parametrised in-order store queue for the out-of-order core's memory stage. Stores are buffered here, drained oldest-first to data memory over a valid/ready request channel, and forwarded to younger loads combinationally. Partial-overlap cases are detected and flagged for stall. Forwarding supports both word (SW/LW) and byte (SB/LB) granularity.

Parameters:
DEPTH, 16, number of store entries; power of 2, at least 2
ADDR_W, 32, byte address width
DATA_W, 32, data width; fixed at 32 (4 byte lanes)
IDX_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous reset, active-high
enq_valid  in  1  store offered
enq_ready  out  1  queue can accept; equals !full
enq_addr  in  ADDR_W  store byte address; for SW, bits [1:0] are ignored
enq_data  in  DATA_W  store data; for SB, only bits [7:0] are used
enq_byte  in  1  1=SB, 0=SW
mem_req_valid  out  1  head entry presented to memory
mem_req_ready  in  1  memory accepts the head entry
mem_addr  out  ADDR_W  head word address, bits [1:0] = 00
mem_data  out  DATA_W  head data, already in its byte lanes
mem_mask  out  4  head byte-lane mask
fwd_addr  in  ADDR_W  load address for lookup
fwd_byte  in  1  1=LB, 0=LW
fwd_hit  out  1  forwarded data valid
fwd_stall  out  1  partial overlap; the load must wait
fwd_data  out  DATA_W  forwarded data; LB returns the raw byte in [7:0], upper bits zero (sign extension is done by the consumer)
count  out  IDX_W+1  occupied entries
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - head, tail and count are set to 0; all entry valid bits are cleared.
  - mem_req_valid=0, full=0, empty=1, enq_ready=1.
  - fwd_hit=0 and fwd_stall=0 from the next cycle onward.
  - Reset overrides any enqueue or handshake in the same cycle. An in-flight mem request is dropped; memory must tolerate this.
- Entry format: valid, word address (ADDR_W-2 bits), 4-bit mask, 32-bit data.
  - SW: mask=1111, data=enq_data.
  - SB: mask=one-hot lane enq_addr[1:0], data = enq_data[7:0] replicated into all lanes (only the masked lane is significant).
- Enqueue: on enq_valid && enq_ready, write the entry at tail, then tail+1 mod DEPTH. The entry is visible to forwarding and drain from the next cycle.
- Drain:
  - mem_req_valid = !empty. mem_* fields come from the head entry and are stable while valid and not ready.
  - On mem_req_valid && mem_req_ready: clear valid at head, then head+1 mod DEPTH.
  - Memory sees stores in strict enqueue order.
- Simultaneous enqueue and drain: count is unchanged and both pointers advance.
  - When full, enq_ready=0 even if a drain occurs that cycle (no same-cycle bypass).
  - When empty, no drain is possible, so there is no enqueue-to-memory passthrough.
- Forwarding (combinational, zero latency):
  - Request mask: LW=1111; LB=one-hot fwd_addr[1:0].
  - Scan all valid entries from youngest (tail-1) to oldest (head), wrapping correctly. Select the youngest entry whose word address matches and whose mask overlaps the request mask.
  - No overlapping entry: hit=0, stall=0, data=0.
  - Selected mask covers the request mask: hit=1, stall=0, data from that entry's lanes.
  - Otherwise: hit=0, stall=1, data=0. A younger SB over an older SW is a stall unless the request is that byte only; multi-entry merging is not performed.
  - The entry being drained this cycle is still searched.
- Wrap-around: pointers are IDX_W bits and count is IDX_W+1 bits, so full and empty are unambiguous.

Decomposition:
- lsu_pkg holds:
  - Type encodings LW=2'b00, LB=2'b01, SW=2'b10, SB=2'b11.
  - The sq_entry_t struct.
  - Function lane_mask(byte, addr[1:0]).
- Sub-module sq_fwd_match: a pure combinational age-ordered priority search. Inputs are the entry array, head, count and request. Outputs are hit, stall and data.

Test Plan:
1. Reset, SW 0x100=0xDEADBEEF, mem_req_ready=0; LW 0x100 next cycle -> fwd_hit=1, fwd_data=0xDEADBEEF, mem_req_valid=1, mem_addr=0x100, mem_mask=1111.
2. SW 0x100=0x11223344, then SB 0x102=0xAA; LW 0x100 -> fwd_stall=1. LB 0x102 -> hit, data=0x000000AA. LB 0x103 -> hit, data=0x00000011.
3. Only SB 0x200=0x55 queued; LW 0x200 -> stall=1, hit=0. LB 0x201 -> hit=0, stall=0. LB 0x200 -> hit, data=0x55.
4. Enqueue 16 stores with ready=0 -> full=1, enq_ready=0, a 17th enqueue is dropped. Pulse ready for one cycle -> count=15 and the oldest store is written first.
5. Enqueue 40 stores with random mem_req_ready and enq_valid -> memory order equals enqueue order, count never exceeds 16, pointers wrap cleanly.
6. Assert reset while mem_req_valid=1 and enq_valid=1 -> next cycle count=0, empty=1, mem_req_valid=0, fwd_hit=0 for an address stored earlier.
